example_4s_scan_ctrl: RTL
=========================

EXAMPLE_4S_SCAN_CTRL -- requirements
Module: example_4s_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, range 1..15; clock cycles each input vector is held before its result is sampled.
REQ-002 The block SHALL have exactly one clock, clk, and a synchronous, active-high reset, rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to scan all 16 vectors; honoured only in IDLE.
REQ-006 abort  input  1  cancels a scan in progress; ignored in IDLE and DONE.
REQ-007 expected  input  16  golden truth table, bit i = expected f for vector i; latched on accepted start.
REQ-008 busy  output  1  high in DRIVE and SAMPLE.
REQ-009 done  output  1  one-cycle pulse on scan completion.
REQ-010 aborted  output  1  one-cycle pulse when abort is taken.
REQ-011 vec  output  4  vector currently applied, {a,b,c,d}, a = MSB.
REQ-012 truth  output  16  captured truth table, bit i = sampled f for vector i.
REQ-013 err_count  output  5  number of mismatching vectors, 0..16.
REQ-014 first_err  output  4  lowest-index mismatching vector; meaningful only when mismatch = 1.
REQ-015 mismatch  output  1  high when err_count != 0.

Function
REQ-016 Internal evaluator, purely combinational on vec: t1=a&b, t2=c&d, t3=a^c, t4=b^d, t5=t1|t2, t6=t3&~t4, f=(t5&~t6)|(t6&~t2).
REQ-017 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-018 IDLE + start -> DRIVE: vec=0, settle counter=0, truth=0, err_count=0, first_err=0, expected latched.
REQ-019 DRIVE: counter increments each cycle; after SETTLE cycles in DRIVE -> SAMPLE.
REQ-020 SAMPLE: truth[vec]<=f; if f != latched expected[vec], err_count += 1, and first_err<=vec when err_count was 0.
REQ-021 SAMPLE with vec<15 -> DRIVE with vec+1, counter=0; SAMPLE with vec=15 -> DONE; vec never wraps mid-scan.
REQ-022 DONE lasts exactly one cycle with done=1, then -> IDLE; vec holds 15.
REQ-023 Latency: start accepted at edge 0 -> done high in cycle 16*(SETTLE+1)+1; SETTLE=1 gives 33.
REQ-024 truth, err_count, first_err, mismatch hold their values in IDLE until the next accepted start.
REQ-025 start while busy or in DONE is ignored; expected changes after acceptance have no effect.
REQ-026 abort in DRIVE or SAMPLE -> IDLE next cycle, aborted=1 for one cycle, done not pulsed, partial results held; the SAMPLE update of that cycle is discarded.
REQ-027 abort and start together in IDLE: start wins, aborted stays 0.
REQ-028 busy is 0 in IDLE and DONE; done and aborted are never high in the same cycle.

Reset
REQ-029 rst high on any edge -> IDLE; busy=0, done=0, aborted=0, vec=0, truth=0, err_count=0, first_err=0, mismatch=0, counter=0, latched expected=0.
REQ-030 rst has priority over start and abort; a scan interrupted by rst is discarded without done or aborted.

Verification
REQ-031 SETTLE=1, expected=16'hF90C, start pulse -> done at cycle 33, truth=16'hF90C, err_count=0, mismatch=0.
REQ-032 expected=16'hF90D -> truth=16'hF90C, err_count=1, first_err=0, mismatch=1.
REQ-033 expected=16'h06F3 (all bits inverted) -> err_count=16, first_err=0; repeat start with 16'hF90C clears to err_count=0.
REQ-034 abort during vector 5 -> aborted pulses once, busy=0 next cycle, no done, truth[15:5]=0, err_count unchanged afterwards.
REQ-035 start re-pulsed at cycles 5 and 20 of a scan -> ignored, single done at cycle 33; SETTLE=3 -> done at cycle 65.
REQ-036 rst asserted at cycle 10 of a scan -> all outputs at reset values next cycle, no done or aborted pulse.

Source files
------------

// File: rtl/example_4s_scan_ctrl.sv
// Exhaustive 4-input scan controller: drives all 16 vectors into a fixed
// combinational evaluator, captures its truth table and compares it against
// a golden table latched at start.
module example_4s_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [3:0]  vec,
  output logic [15:0] truth,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // Last settle count value before the vector is considered stable.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] exp_lat;
  logic        f;

  // Evaluator under test: pure function of the applied vector.
  always_comb begin
    logic a, b, c, d, t1, t2, t3, t4, t5, t6;
    {a, b, c, d} = vec;
    t1 = a & b;
    t2 = c & d;
    t3 = a ^ c;
    t4 = b ^ d;
    t5 = t1 | t2;
    t6 = t3 & ~t4;
    f  = (t5 & ~t6) | (t6 & ~t2);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (abort)                state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (abort)             state_nxt = IDLE;
        else if (vec == 4'hF)  state_nxt = DONE;
        else                   state_nxt = DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath: vector/settle counters, capture and error tracking.
  // An abort in SAMPLE drops that cycle's capture so partial results only
  // cover fully sampled vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted   <= 1'b0;
      vec       <= '0;
      cnt       <= '0;
      truth     <= '0;
      err_count <= '0;
      first_err <= '0;
      exp_lat   <= '0;
    end else begin
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            truth     <= '0;
            err_count <= '0;
            first_err <= '0;
            exp_lat   <= expected;
          end
        end
        DRIVE: begin
          if (abort) aborted <= 1'b1;
          else       cnt     <= cnt + 4'd1;
        end
        SAMPLE: begin
          if (abort) begin
            aborted <= 1'b1;
          end else begin
            truth[vec] <= f;
            if (f != exp_lat[vec]) begin
              err_count <= err_count + 5'd1;
              if (err_count == 5'd0) first_err <= vec;
            end
            if (vec != 4'hF) begin
              vec <= vec + 4'd1;
              cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mismatch = (err_count != 5'd0);

endmodule
